// File: rtl/dial_pkg.sv
// rtl/dial_pkg.sv - shared FSM state type and datapath control constants for the dial scheduler
package dial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_READ  = 3'd3,
      ST_RESP  = 3'd4
   } sched_state_t;

   // datapath output select values driven on control[2:0]
   localparam logic [2:0] SEL_RAW    = 3'd0;
   localparam logic [2:0] SEL_ANSWER = 3'd3;

   // control bit carrying the part-B mode flag
   localparam int PART_B_BIT = 3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO, full/empty from an extra pointer wrap bit
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk_slow,
   input  logic             rst,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             do_wr, do_rd;

   assign do_wr = wr_en_i && !full_o;
   assign do_rd = rd_en_i && !empty_o;

   // advance each pointer on an accepted write or read
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   // pointer registers, cleared by reset so the queue flushes
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // storage array; contents are don't-care while empty so no reset
   always_ff @(posedge clk_slow) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/dial_cmd_scheduler.sv
// rtl/dial_cmd_scheduler.sv - issues queued rotation deltas to the dial datapath; WAIT watchdog under DIAL_SCHED_TIMEOUT_EN
module dial_cmd_scheduler
   import dial_pkg::*;
#(
   parameter int WIDTH_DIN   = 128,
   parameter int WIDTH_CMD   = 32,
   parameter int DEPTH       = 8,
   parameter int LOAD_CYCLES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                 clk_slow,
   input  logic                 rst,
   input  logic [WIDTH_CMD-1:0] cmd_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 rd_req,
   input  logic                 part_b,
   output logic [WIDTH_DIN-1:0] dp_din,
   output logic                 dp_din_valid,
   input  logic                 dp_done,
   output logic [5:0]           dp_control,
   output logic                 resp_valid,
   output logic                 busy,
   output logic [31:0]          cmd_count,
   output logic                 err_timeout
);

   localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
   localparam logic [LC_W-1:0] LOAD_LAST = LC_W'(LOAD_CYCLES - 1);

   sched_state_t         state_q;
   logic [LC_W-1:0]      load_cnt_q;
   logic                 rd_pend_q;
   logic [WIDTH_DIN-1:0] dp_din_q;
   logic                 dp_din_valid_q;
   logic                 resp_valid_q;
   logic [2:0]           sel_q;
   logic [31:0]          cmd_count_q;
   logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [WIDTH_CMD-1:0] fifo_head;
   logic                 wait_expired;

   assign cmd_ready = !fifo_full && !rst;
   assign fifo_push = cmd_valid && cmd_ready;
   // the head leaves the queue on the final load cycle of its burst
   assign fifo_pop  = (state_q == ST_ISSUE) && (load_cnt_q == LOAD_LAST);

   sync_fifo #(
      .WIDTH (WIDTH_CMD),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk_slow  (clk_slow),
      .rst       (rst),
      .wr_data_i (cmd_data),
      .wr_en_i   (fifo_push),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

`ifdef DIAL_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt_q;
   logic          err_q;

   // count WAIT cycles and latch the sticky flag when the datapath never answers
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (state_q != ST_WAIT) wait_cnt_q <= '0;
         else                    wait_cnt_q <= wait_cnt_q + TW'(1);
         if (wait_expired)       err_q      <= 1'b1;
      end
   end

   assign wait_expired = (state_q == ST_WAIT) && !dp_done && (wait_cnt_q == TW'(TIMEOUT - 1));
   assign err_timeout  = err_q;
`else
   localparam int unused_timeout = TIMEOUT;
   assign wait_expired = 1'b0;
   assign err_timeout  = 1'b0;
`endif

   // command/read sequencer; every datapath-facing output is registered here
   always_ff @(posedge clk_slow) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         load_cnt_q     <= '0;
         rd_pend_q      <= 1'b0;
         dp_din_q       <= '0;
         dp_din_valid_q <= 1'b0;
         resp_valid_q   <= 1'b0;
         sel_q          <= SEL_RAW;
         cmd_count_q    <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         if (rd_req) rd_pend_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               // a pending read waits until every queued command has been issued
               if (rd_pend_q && fifo_empty) begin
                  state_q <= ST_READ;
                  sel_q   <= SEL_ANSWER;
               end else if (!fifo_empty) begin
                  state_q        <= ST_ISSUE;
                  load_cnt_q     <= '0;
                  dp_din_valid_q <= 1'b1;
                  dp_din_q       <= {{(WIDTH_DIN - WIDTH_CMD){fifo_head[WIDTH_CMD-1]}}, fifo_head};
               end
            end
            ST_ISSUE: begin
               if (load_cnt_q == LOAD_LAST) begin
                  state_q        <= ST_WAIT;
                  dp_din_valid_q <= 1'b0;
                  dp_din_q       <= '0;
                  cmd_count_q    <= cmd_count_q + 32'd1;
               end else begin
                  load_cnt_q <= load_cnt_q + LC_W'(1);
               end
            end
            ST_WAIT: begin
               if (dp_done || wait_expired) state_q <= ST_IDLE;
            end
            ST_READ: begin
               // clearing here also swallows a repeat request made during READ
               state_q      <= ST_RESP;
               resp_valid_q <= 1'b1;
               rd_pend_q    <= 1'b0;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               sel_q   <= SEL_RAW;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // assemble the control word: select lines plus the mode bit passed straight through
   always_comb begin
      dp_control             = '0;
      dp_control[2:0]        = sel_q;
      dp_control[PART_B_BIT] = part_b;
   end

   assign dp_din       = dp_din_q;
   assign dp_din_valid = dp_din_valid_q;
   assign resp_valid   = resp_valid_q;
   assign cmd_count    = cmd_count_q;
   assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dial_cmd_scheduler.sv
// tb/tb_dial_cmd_scheduler.sv - self-checking bench for dial_cmd_scheduler (honours DIAL_SCHED_TIMEOUT_EN)
module tb_dial_cmd_scheduler;

   localparam int WIDTH_DIN   = 128;
   localparam int WIDTH_CMD   = 32;
   localparam int DEPTH       = 8;
   localparam int LOAD_CYCLES = 2;
`ifdef DIAL_SCHED_TIMEOUT_EN
   localparam int TIMEOUT = 16;
   localparam bit TO_EN   = 1'b1;
`else
   localparam int TIMEOUT = 1024;
   localparam bit TO_EN   = 1'b0;
`endif

   logic                 clk_slow, rst, cmd_valid, cmd_ready, rd_req, part_b;
   logic                 dp_din_valid, dp_done, resp_valid, busy, err_timeout;
   logic [WIDTH_CMD-1:0] cmd_data;
   logic [WIDTH_DIN-1:0] dp_din;
   logic [5:0]           dp_control;
   logic [31:0]          cmd_count;

   dial_cmd_scheduler #(
      .WIDTH_DIN   (WIDTH_DIN),
      .WIDTH_CMD   (WIDTH_CMD),
      .DEPTH       (DEPTH),
      .LOAD_CYCLES (LOAD_CYCLES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk_slow     (clk_slow),
      .rst          (rst),
      .cmd_data     (cmd_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .rd_req       (rd_req),
      .part_b       (part_b),
      .dp_din       (dp_din),
      .dp_din_valid (dp_din_valid),
      .dp_done      (dp_done),
      .dp_control   (dp_control),
      .resp_valid   (resp_valid),
      .busy         (busy),
      .cmd_count    (cmd_count),
      .err_timeout  (err_timeout)
   );

   initial begin
      clk_slow = 1'b0;
      forever #5 clk_slow = ~clk_slow;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // staged stimulus, applied at the next falling edge
   logic        s_rst = 1'b1, s_cmd_valid = 1'b0, s_rd_req = 1'b0, s_part_b = 1'b0, s_done_pulse = 1'b0;
   logic [31:0] s_cmd_data = '0;
   int          done_mode = 0;

   // reference model: queue of deltas plus a few counters describing the current activity
   logic [31:0] mq[$];
   int          strobe_left = 0;
   bit          awaiting    = 1'b0;
   int          wait_cycles = 0;
   int          read_stage  = 0;
   bit          rd_pend_m   = 1'b0;
   logic [31:0] count_m     = '0;
   bit          err_m       = 1'b0;
   int          since_issue = 100;

   logic [127:0] cap[$];
   int           resp_cnt = 0, last_resp_cyc = -1, last_done_cyc = -1;
   logic [2:0]   resp_sel = '0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, got, exp);
      end
   endtask

   function automatic logic [127:0] sext(input logic [31:0] v);
      logic signed [31:0]  s;
      logic signed [127:0] w;
      s = v;
      w = s;
      return w;
   endfunction

   task automatic model_update();
      bit idle;
      int sz;
      bit push;
      bit rdp;
      since_issue++;
      if (rst) begin
         mq.delete();
         strobe_left = 0; awaiting = 1'b0; wait_cycles = 0; read_stage = 0;
         rd_pend_m = 1'b0; count_m = '0; err_m = 1'b0;
         return;
      end
      idle = (strobe_left == 0) && !awaiting && (read_stage == 0);
      sz   = mq.size();
      push = cmd_valid && (sz < DEPTH);
      rdp  = rd_pend_m;
      if (read_stage == 1) begin
         read_stage = 2;
         rd_pend_m  = 1'b0;
      end else begin
         if (rd_req) rd_pend_m = 1'b1;
         if (read_stage == 2) read_stage = 0;
         else if (strobe_left > 0) begin
            strobe_left--;
            if (strobe_left == 0) begin
               void'(mq.pop_front());
               count_m     = count_m + 1;
               awaiting    = 1'b1;
               wait_cycles = 0;
            end
         end else if (awaiting) begin
            if (dp_done) awaiting = 1'b0;
            else begin
               wait_cycles++;
               if (TO_EN && wait_cycles == TIMEOUT) begin
                  awaiting = 1'b0;
                  err_m    = 1'b1;
               end
            end
         end else if (idle && rdp && sz == 0) read_stage = 1;
         else if (idle && sz > 0) begin
            strobe_left = LOAD_CYCLES;
            since_issue = 0;
         end
      end
      if (push) mq.push_back(cmd_data);
   endtask

   // one clock: drive inputs, compare every output against the model, advance the model
   task automatic step();
      bit           exp_idle;
      logic [127:0] exp_din;
      @(negedge clk_slow);
      rst       = s_rst;
      cmd_valid = s_cmd_valid;
      cmd_data  = s_cmd_data;
      rd_req    = s_rd_req;
      part_b    = s_part_b;
      case (done_mode)
         0:       dp_done = ($urandom_range(3) == 0);
         1:       dp_done = awaiting && (since_issue == 5);
         default: dp_done = 1'b0;
      endcase
      if (s_done_pulse) dp_done = 1'b1;
      s_done_pulse = 1'b0;
      #1;
      exp_idle = (strobe_left == 0) && !awaiting && (read_stage == 0);
      exp_din  = (strobe_left > 0) ? sext(mq[0]) : '0;
      chk("cmd_ready",    128'(cmd_ready),    128'(!rst && (mq.size() < DEPTH)));
      chk("dp_din_valid", 128'(dp_din_valid), 128'(strobe_left > 0));
      chk("dp_din",       dp_din,             exp_din);
      chk("dp_control",   128'(dp_control),   128'({2'b00, part_b, (read_stage != 0) ? 3'd3 : 3'd0}));
      chk("resp_valid",   128'(resp_valid),   128'(read_stage == 2));
      chk("busy",         128'(busy),         128'(!exp_idle || (mq.size() > 0)));
      chk("cmd_count",    128'(cmd_count),    128'(count_m));
      chk("err_timeout",  128'(err_timeout),  128'(err_m));
      if (dp_done && awaiting && !rst) last_done_cyc = cyc;
      if (resp_valid) begin
         resp_cnt++;
         last_resp_cyc = cyc;
         resp_sel = dp_control[2:0];
      end
      if (dp_din_valid) cap.push_back(dp_din);
      model_update();
      cyc++;
   endtask

   task automatic idle_n(input int n);
      s_cmd_valid = 1'b0;
      s_rd_req    = 1'b0;
      repeat (n) step();
   endtask

   task automatic push(input logic [31:0] d, input bit rq);
      s_cmd_valid = 1'b1;
      s_cmd_data  = d;
      s_rd_req    = rq;
      step();
      s_cmd_valid = 1'b0;
      s_rd_req    = 1'b0;
   endtask

   initial begin
      int first, req_cyc, pc, ec;
      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rd_req = 1'b0; part_b = 1'b0; dp_done = 1'b0;
      repeat (2) @(posedge clk_slow);

      // reset state
      done_mode = 2;
      step();
      chk("reset_ready", 128'(cmd_ready), 128'(1'b0));
      chk("reset_outs",  128'({dp_din_valid, resp_valid, busy, dp_control, err_timeout}), 128'(0));
      chk("reset_count", 128'(cmd_count), 128'(0));
      s_rst = 1'b0;
      step();
      chk("ready_after_reset", 128'(cmd_ready), 128'(1'b1));

      // three commands, datapath answers 5 cycles after each strobe
      done_mode = 1;
      cap.delete();
      push(32'd30, 1'b0);
      push(-32'sd68, 1'b0);
      push(32'd48, 1'b0);
      idle_n(30);
      chk("t1_strobes", 128'(cap.size()), 128'(6));
      chk("t1_din0", cap[0], 128'h1E);
      chk("t1_din1", cap[1], 128'h1E);
      chk("t1_din2", cap[2], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFBC);
      chk("t1_din4", cap[4], 128'h30);
      chk("t1_count", 128'(cmd_count), 128'(3));

      // fill the queue while the datapath is stalled
      done_mode = 2;
      push(32'd7, 1'b0);
      idle_n(6);
      for (int i = 0; i < 8; i++) push(32'(100 + i), 1'b0);
      idle_n(1);
      chk("t2_full_ready", 128'(cmd_ready), 128'(1'b0));
      push(32'hDEAD_BEEF, 1'b0);
      chk("t2_drop_ready", 128'(cmd_ready), 128'(1'b0));
      s_done_pulse = 1'b1;
      first = -1;
      for (int i = 0; i < 10 && first < 0; i++) begin
         step();
         if (dp_din_valid) first = cyc - 1;
      end
      chk("t2_issue_seen", 128'(first >= 0), 128'(1'b1));
      step();
      chk("t2_ready_at_pop", 128'(cmd_ready), 128'(1'b0));
      step();
      chk("t2_ready_after_pop", 128'(cmd_ready), 128'(1'b1));
      done_mode = 1;
      cap.delete();
      idle_n(90);
      chk("t2_drained_strobes", 128'(cap.size()), 128'(14));
      chk("t2_count", 128'(cmd_count), 128'(12));
      chk("t2_idle", 128'(busy), 128'(1'b0));

      // read request behind two queued commands
      resp_cnt = 0;
      push(32'd5, 1'b0);
      push(32'hFFFF_FFF0, 1'b1);
      idle_n(40);
      chk("t3_resp_cnt", 128'(resp_cnt), 128'(1));
      chk("t3_resp_lat", 128'(last_resp_cyc - last_done_cyc), 128'(3));
      chk("t3_resp_sel", 128'(resp_sel), 128'(3));
      chk("t3_count", 128'(cmd_count), 128'(14));

      // two close read requests produce one response
      resp_cnt = 0;
      s_rd_req = 1'b1;
      step();
      req_cyc = cyc - 1;
      s_rd_req = 1'b0;
      step();
      s_rd_req = 1'b1;
      step();
      idle_n(12);
      chk("t4_resp_cnt", 128'(resp_cnt), 128'(1));
      chk("t4_resp_lat", 128'(last_resp_cyc - req_cyc), 128'(3));

      // reset while waiting with commands queued
      done_mode = 2;
      push(32'd9, 1'b0);
      idle_n(4);
      push(32'd1, 1'b0);
      push(32'd2, 1'b0);
      push(32'd3, 1'b0);
      s_rst = 1'b1;
      step();
      chk("t5_ready_in_rst", 128'(cmd_ready), 128'(1'b0));
      s_rst = 1'b0;
      step();
      chk("t5_outs", 128'({dp_din_valid, resp_valid, busy, dp_control[2:0], err_timeout}), 128'(0));
      chk("t5_count", 128'(cmd_count), 128'(0));
      chk("t5_ready", 128'(cmd_ready), 128'(1'b1));
      idle_n(5);
      chk("t5_flushed", 128'(busy), 128'(1'b0));

`ifdef DIAL_SCHED_TIMEOUT_EN
      // watchdog: no dp_done at all
      push(32'd1, 1'b0);
      pc = cyc - 1;
      push(32'd2, 1'b0);
      ec = -1;
      for (int i = 0; i < 40 && ec < 0; i++) begin
         step();
         if (err_timeout) ec = cyc - 1;
      end
      chk("t6_to_lat", 128'(ec - pc), 128'(20));
      cap.delete();
      idle_n(4);
      chk("t6_next_issue", 128'(cap.size()), 128'(2));
      chk("t6_next_din", cap[0], 128'h2);
      idle_n(20);
      chk("t6_sticky", 128'(err_timeout), 128'(1'b1));
      chk("t6_count", 128'(cmd_count), 128'(2));
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      step();
      chk("t6_cleared", 128'(err_timeout), 128'(1'b0));
`else
      pc = 0;
      ec = 0;
`endif

      // randomized traffic against the model
      done_mode = 0;
      for (int i = 0; i < 4000; i++) begin
         s_cmd_valid = ($urandom_range(99) < (((i / 500) % 2 == 1) ? 10 : 50));
         s_cmd_data  = $urandom;
         s_rd_req    = ($urandom_range(15) == 0);
         s_part_b    = 1'($urandom_range(1));
         s_rst       = ($urandom_range(299) == 0);
         step();
      end
      s_cmd_valid = 1'b0;
      s_rd_req    = 1'b0;
      s_rst       = 1'b0;
      idle_n(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
